execute_stage_m: RTL and testbench
==================================

// Module: execute_stage_m
// PURPOSE
//  Parametrised RV32IM execute stage for the 5-stage pipeline: forwarding muxes, ALU, branch/jump
//  resolution, optional iterative divide unit, and the EX/MEM pipeline register.
//  Sits between the ID/EX register and the memory stage. Signals the hazard unit to stall while a
//  divide runs.
// PARAMETERS
//  DATA_WIDTH              32  datapath/XLEN width; divider runs DATA_WIDTH iterations
//  REG_FILE_ADDRESS_WIDTH  5   register index width
//  ALU_CTRL_WIDTH          5   ALUControl width (widened from 4 for M-extension ops)
// PORTS
//  clk          in  1    clock, rising edge
//  rst_n        in  1    asynchronous reset, active low
//  RegWriteE    in  1    ID/EX: writeback enable
//  ResultSrcE   in  2    ID/EX: result select (00 ALU, 01 mem, 10 PC+4)
//  MemWriteE    in  1    ID/EX: store enable
//  JumpE        in  1    ID/EX: JAL/JALR
//  BranchE      in  1    ID/EX: conditional branch
//  Funct3E      in  3    ID/EX: branch condition (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//  ALUControlE  in  5    ID/EX: ALU op (riscv_pkg::alu_op_t)
//  ALUSrcE      in  1    ID/EX: 1 = ExtImmE as operand B
//  RD1E, RD2E   in  DW   ID/EX: register file read data
//  PCE          in  DW   ID/EX: PC of instruction
//  RdE          in  RAW  ID/EX: destination register
//  ExtImmE      in  DW   ID/EX: sign-extended immediate
//  PCPlus4E     in  DW   ID/EX: PC+4
//  ForwardAE    in  2    fwd select A: 00 RD1E, 01 ResultW, 10 ALUResultM, 11 reserved (=RD1E)
//  ForwardBE    in  2    fwd select B: same encoding on RD2E
//  ResultW      in  DW   writeback-stage result for forwarding
//  PCSrcE       out 1    redirect fetch (taken branch or jump)
//  PCTargetE    out DW   redirect target
//  BusyE        out 1    divide in progress; hazard unit stalls F/D/E
//  RegWriteM, ResultSrcM(2), MemWriteM  out  EX/MEM control
//  ALUResultM, WriteDataM, PCPlus4M     out DW  EX/MEM data; RdM out RAW
// BEHAVIOUR
//  - Reset: all EX/MEM outputs 0, divider FSM IDLE, BusyE 0. Reset mid-divide aborts it; no result.
//  - SrcA = fwd(RD1E); WriteData = fwd(RD2E); SrcB = ALUSrcE ? ExtImmE : WriteData.
//  - ALU/MUL ops: combinational, 1-cycle latency; registered to M on next rising edge.
//  - MUL/MULH/MULHSU/MULHU: 2*DW-bit product, low or high half; signedness per op.
//  - PCTargetE: JALR -> (SrcA+ExtImmE) & ~1; else PCE+ExtImmE. PCSrcE = JumpE | (BranchE & cond).
//  - Divider FSM (DIV/DIVU/REM/REMU), states IDLE, RUN, DONE:
//    IDLE: div op in E -> BusyE=1 (combinational), latch |operands|, signs, op; count=0 -> RUN.
//          divisor 0 or (MIN / -1 signed) -> straight to DONE with special result.
//    RUN:  one restoring shift-subtract step per cycle; BusyE=1; after DW steps -> DONE.
//    DONE: BusyE=0; sign-corrected result drives ALUResult, written to M this edge; -> IDLE.
//  - Latency: normal divide DW+2 cycles in E; special cases 2 cycles.
//  - While BusyE=1 EX/MEM loads a bubble: RegWriteM=0, MemWriteM=0, other fields don't-care.
//  - Operands latched at start; forwarding changes during RUN are ignored.
//  - Div-by-zero: DIV/DIVU quotient all ones, REM/REMU = dividend. Overflow: quotient MIN, rem 0.
//  - PCSrcE never asserted by a divide (not a branch); branches never coincide with BusyE.
// CONFIGURATION
//  MULDIV_EN defined: M-extension ops and divider present as above.
//  Not defined: no multiplier/divider logic; M ops give ALUResult 0; BusyE tied 0.
// STRUCTURE
//  riscv_pkg: alu_op_t enum (ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND,LUI,MUL..REMU),
//             fwd_sel_t, funct3 branch constants, div_state_t.
//  Sub-module: iterative_divider (FSM + shift-subtract datapath), instantiated under MULDIV_EN.
// TESTING
//  ADD RD1E=5, imm=7, ALUSrcE=1 -> next edge ALUResultM=12, RegWriteM=1.
//  ForwardAE=10, ALUResultM=0x10, RD1E=0, ADD, RD2E=1 -> ALUResultM=0x11; ForwardAE=01 takes ResultW.
//  BEQ SrcA=SrcB=3, PCE=0x100, imm=0x20 -> PCSrcE=1, PCTargetE=0x120; BNE same -> PCSrcE=0.
//  DIV -7/2: BusyE=1 for 33 cycles, bubbles in M, then ALUResultM=0xFFFFFFFD; REM gives 0xFFFFFFFF.
//  DIVU 5/0 -> 2-cycle busy, 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
//  rst_n low at RUN step 10 -> BusyE=0, M outputs 0; re-issued DIV completes correctly.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32IM execute-stage types: ALU op encodings, forwarding selects, branch funct3, divider states.
// The M-extension encodings are always defined; whether they are implemented depends on MULDIV_EN.
package riscv_pkg;

    localparam int unsigned ALU_OP_WIDTH = 5;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_LUI    = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10,
        FWD_RSVD = 2'b11
    } fwd_sel_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_RUN  = 2'b01,
        DIV_DONE = 2'b10
    } div_state_t;

    function automatic logic is_div_op(alu_op_t op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/iterative_divider.sv
// Iterative restoring divider: one shift-subtract step per cycle on operand magnitudes, sign fixed up in DONE.
// Instantiated by execute_stage_m only when MULDIV_EN is defined.
module iterative_divider
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic                  is_rem,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    div_state_t            state;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] den;
    logic                  neg_q;
    logic                  neg_r;
    logic                  rem_sel;

    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_WIDTH-1:0] a_abs;
    logic [DATA_WIDTH-1:0] b_abs;
    logic                  div_zero;
    logic                  overflow;
    logic [DATA_WIDTH+1:0] trial;
    logic [DATA_WIDTH-1:0] q_fix;
    logic [DATA_WIDTH-1:0] r_fix;

    always_comb begin
        a_neg    = is_signed & dividend[DATA_WIDTH-1];
        b_neg    = is_signed & divisor[DATA_WIDTH-1];
        a_abs    = a_neg ? ('0 - dividend) : dividend;
        b_abs    = b_neg ? ('0 - divisor) : divisor;
        div_zero = (divisor == '0);
        overflow = is_signed & (dividend == MIN_VAL) & (divisor == '1);
        // Extra top bit keeps the borrow visible: negative trial means "restore".
        trial    = {1'b0, rem, quo[DATA_WIDTH-1]} - {2'b00, den};
        q_fix    = neg_q ? ('0 - quo) : quo;
        r_fix    = neg_r ? ('0 - rem) : rem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= DIV_IDLE;
            count   <= '0;
            quo     <= '0;
            rem     <= '0;
            den     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            rem_sel <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        rem_sel <= is_rem;
                        count   <= '0;
                        if (div_zero) begin
                            quo   <= '1;
                            rem   <= dividend;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= DIV_DONE;
                        end else if (overflow) begin
                            quo   <= MIN_VAL;
                            rem   <= '0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= DIV_DONE;
                        end else begin
                            quo   <= a_abs;
                            rem   <= '0;
                            den   <= b_abs;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                            state <= DIV_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    if (!trial[DATA_WIDTH+1]) begin
                        rem <= trial[DATA_WIDTH-1:0];
                        quo <= {quo[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= {rem[DATA_WIDTH-2:0], quo[DATA_WIDTH-1]};
                        quo <= {quo[DATA_WIDTH-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state <= DIV_DONE;
                    end
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

    // Busy is raised combinationally on issue so the first cycle already stalls the front end.
    assign busy   = rst_n & (((state == DIV_IDLE) & start) | (state == DIV_RUN));
    assign done   = (state == DIV_DONE);
    assign result = rem_sel ? r_fix : q_fix;

endmodule

// File: rtl/execute_stage_m.sv
// RV32IM execute stage: forwarding, ALU, branch/jump resolution, optional divider, EX/MEM register.
// Define MULDIV_EN to build the multiplier and iterative divider; otherwise M ops yield 0 and BusyE is 0.
module execute_stage_m
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH             = 32,
    parameter int unsigned REG_FILE_ADDRESS_WIDTH = 5,
    parameter int unsigned ALU_CTRL_WIDTH         = 5
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              RegWriteE,
    input  logic [1:0]                        ResultSrcE,
    input  logic                              MemWriteE,
    input  logic                              JumpE,
    input  logic                              BranchE,
    input  logic [2:0]                        Funct3E,
    input  logic [ALU_CTRL_WIDTH-1:0]         ALUControlE,
    input  logic                              ALUSrcE,
    input  logic [DATA_WIDTH-1:0]             RD1E,
    input  logic [DATA_WIDTH-1:0]             RD2E,
    input  logic [DATA_WIDTH-1:0]             PCE,
    input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdE,
    input  logic [DATA_WIDTH-1:0]             ExtImmE,
    input  logic [DATA_WIDTH-1:0]             PCPlus4E,
    input  logic [1:0]                        ForwardAE,
    input  logic [1:0]                        ForwardBE,
    input  logic [DATA_WIDTH-1:0]             ResultW,
    output logic                              PCSrcE,
    output logic [DATA_WIDTH-1:0]             PCTargetE,
    output logic                              BusyE,
    output logic                              RegWriteM,
    output logic [1:0]                        ResultSrcM,
    output logic                              MemWriteM,
    output logic [DATA_WIDTH-1:0]             ALUResultM,
    output logic [DATA_WIDTH-1:0]             WriteDataM,
    output logic [DATA_WIDTH-1:0]             PCPlus4M,
    output logic [REG_FILE_ADDRESS_WIDTH-1:0] RdM
);

    localparam int unsigned SH_W = $clog2(DATA_WIDTH);

    alu_op_t               op;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [SH_W-1:0]       shamt;
    logic                  lt_s;
    logic                  lt_u;
    logic                  eq;
    logic                  taken;
    logic                  is_jalr;
    logic [DATA_WIDTH-1:0] jalr_sum;

    assign op = alu_op_t'(ALUControlE);

    always_comb begin
        case (fwd_sel_t'(ForwardAE))
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALUResultM;
            default: src_a = RD1E;
        endcase
        case (fwd_sel_t'(ForwardBE))
            FWD_WB:  write_data = ResultW;
            FWD_MEM: write_data = ALUResultM;
            default: write_data = RD2E;
        endcase
        src_b = ALUSrcE ? ExtImmE : write_data;
    end

    assign shamt = src_b[SH_W-1:0];
    assign lt_s  = $signed(src_a) < $signed(src_b);
    assign lt_u  = src_a < src_b;
    assign eq    = (src_a == src_b);

`ifdef MULDIV_EN
    logic                    mul_a_signed;
    logic                    mul_b_signed;
    logic [2*DATA_WIDTH-1:0] mul_a;
    logic [2*DATA_WIDTH-1:0] mul_b;
    logic [2*DATA_WIDTH-1:0] product;
    logic                    div_busy;
    logic                    div_done;
    logic [DATA_WIDTH-1:0]   div_result;

    // Sign-extending to 2*DW lets one unsigned multiply serve all four signedness combinations.
    always_comb begin
        mul_a_signed = (op == ALU_MULH) | (op == ALU_MULHSU);
        mul_b_signed = (op == ALU_MULH);
        mul_a   = {{DATA_WIDTH{mul_a_signed & src_a[DATA_WIDTH-1]}}, src_a};
        mul_b   = {{DATA_WIDTH{mul_b_signed & src_b[DATA_WIDTH-1]}}, src_b};
        product = mul_a * mul_b;
    end

    iterative_divider #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (is_div_op(op)),
        .is_signed((op == ALU_DIV) | (op == ALU_REM)),
        .is_rem   ((op == ALU_REM) | (op == ALU_REMU)),
        .dividend (src_a),
        .divisor  (src_b),
        .busy     (div_busy),
        .done     (div_done),
        .result   (div_result)
    );

    assign BusyE = div_busy;
`else
    assign BusyE = 1'b0;
`endif

    always_comb begin
        alu_result = '0;
        case (op)
            ALU_ADD:    alu_result = src_a + src_b;
            ALU_SUB:    alu_result = src_a - src_b;
            ALU_SLL:    alu_result = src_a << shamt;
            ALU_SLT:    alu_result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU:   alu_result = {{(DATA_WIDTH-1){1'b0}}, lt_u};
            ALU_XOR:    alu_result = src_a ^ src_b;
            ALU_SRL:    alu_result = src_a >> shamt;
            ALU_SRA:    alu_result = $unsigned($signed(src_a) >>> shamt);
            ALU_OR:     alu_result = src_a | src_b;
            ALU_AND:    alu_result = src_a & src_b;
            ALU_LUI:    alu_result = src_b;
`ifdef MULDIV_EN
            ALU_MUL:    alu_result = product[DATA_WIDTH-1:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  alu_result = product[2*DATA_WIDTH-1:DATA_WIDTH];
            ALU_DIV,
            ALU_DIVU,
            ALU_REM,
            ALU_REMU:   alu_result = div_done ? div_result : '0;
`endif
            default:    alu_result = '0;
        endcase
    end

    always_comb begin
        case (Funct3E)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = ~eq;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = ~lt_s;
            F3_BLTU: taken = lt_u;
            F3_BGEU: taken = ~lt_u;
            default: taken = 1'b0;
        endcase
    end

    // JAL is decoded with ALUSrcE=0; JALR uses the immediate as operand B, which identifies it here.
    assign is_jalr   = JumpE & ALUSrcE;
    assign jalr_sum  = src_a + ExtImmE;
    assign PCTargetE = is_jalr ? {jalr_sum[DATA_WIDTH-1:1], 1'b0} : (PCE + ExtImmE);
    assign PCSrcE    = JumpE | (BranchE & taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteM  <= 1'b0;
            ResultSrcM <= '0;
            MemWriteM  <= 1'b0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            RdM        <= '0;
        end else begin
            RegWriteM  <= RegWriteE & ~BusyE;
            MemWriteM  <= MemWriteE & ~BusyE;
            ResultSrcM <= ResultSrcE;
            ALUResultM <= alu_result;
            WriteDataM <= write_data;
            PCPlus4M   <= PCPlus4E;
            RdM        <= RdE;
        end
    end

endmodule

// File: tb/tb_execute_stage_m.sv
// Directed bench for execute_stage_m: vector table for ALU/forwarding/branch, sequences for divide and reset.
// Divider sequences are exercised when MULDIV_EN is defined; otherwise M ops are checked to give 0.
module tb_execute_stage_m;
    import riscv_pkg::*;

`ifdef MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic [2:0]  Funct3E;
    logic [4:0]  ALUControlE, RdE, RdM;
    logic [31:0] RD1E, RD2E, PCE, ExtImmE, PCPlus4E, ResultW;
    logic        PCSrcE, BusyE, RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    execute_stage_m #(
        .DATA_WIDTH(32),
        .REG_FILE_ADDRESS_WIDTH(5),
        .ALU_CTRL_WIDTH(5)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .Funct3E(Funct3E), .ALUControlE(ALUControlE),
        .ALUSrcE(ALUSrcE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .RdE(RdE),
        .ExtImmE(ExtImmE), .PCPlus4E(PCPlus4E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BusyE(BusyE),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        alu_op_t     op;
        logic        src;
        logic [1:0]  fa, fb;
        logic [31:0] rd1, rd2, imm, resw;
        logic        jump, branch;
        logic [2:0]  f3;
        logic [31:0] exp_alu, exp_wd;
        logic        exp_pcsrc;
        logic [31:0] exp_tgt;
    } vec_t;

    function automatic vec_t mk(input string name, input alu_op_t op, input logic src,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] imm, input logic [31:0] resw,
                                input logic jump, input logic branch, input logic [2:0] f3,
                                input logic [31:0] exp_alu, input logic [31:0] exp_wd,
                                input logic exp_pcsrc, input logic [31:0] exp_tgt);
        vec_t v;
        v.name = name; v.op = op; v.src = src; v.fa = fa; v.fb = fb;
        v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.resw = resw;
        v.jump = jump; v.branch = branch; v.f3 = f3;
        v.exp_alu = exp_alu; v.exp_wd = exp_wd; v.exp_pcsrc = exp_pcsrc; v.exp_tgt = exp_tgt;
        return v;
    endfunction

    task automatic check_m_zero(input string tag);
        check({tag, "_regwrite_m"}, RegWriteM, 0);
        check({tag, "_memwrite_m"}, MemWriteM, 0);
        check({tag, "_resultsrc_m"}, ResultSrcM, 0);
        check({tag, "_alu_m"}, ALUResultM, 0);
        check({tag, "_wd_m"}, WriteDataM, 0);
        check({tag, "_pcplus4_m"}, PCPlus4M, 0);
        check({tag, "_rd_m"}, RdM, 0);
        check({tag, "_busy"}, BusyE, 0);
    endtask

    // Issues a divide at posedge+1 and plays the hazard unit: holds the op while BusyE is high.
    task automatic run_div(input string name, input alu_op_t op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int busy_n;
        ALUControlE = op; RD1E = a; RD2E = b; ALUSrcE = 1'b0;
        ForwardAE = 2'b00; ForwardBE = 2'b00; JumpE = 1'b0; BranchE = 1'b0;
        RegWriteE = 1'b1; MemWriteE = 1'b0; RdE = 5'd9; PCPlus4E = 32'h0000_3004;
        #1;
        check({name, "_busy_issue"}, BusyE, 1);
        check({name, "_pcsrc"}, PCSrcE, 0);
        busy_n = 1;
        while (BusyE === 1'b1 && busy_n < 100) begin
            @(posedge clk); #1;
            // Operand changes after issue must be ignored by the divider.
            RD1E = 32'hDEAD_BEEF; RD2E = 32'h0000_0003; ForwardAE = 2'b01; ResultW = 32'h1234_5678;
            #1;
            check({name, "_bubble_regwrite"}, RegWriteM, 0);
            if (BusyE === 1'b1) busy_n++;
        end
        check({name, "_busy_released"}, BusyE, 0);
        @(posedge clk); #1;
        check({name, "_result"}, ALUResultM, exp_res);
        check({name, "_regwrite"}, RegWriteM, 1);
        check({name, "_rd"}, RdM, 9);
        check({name, "_latency"}, busy_n + 1, exp_lat);
        ALUControlE = ALU_ADD; ForwardAE = 2'b00;
    endtask

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        RegWriteE = 1'b1; MemWriteE = 1'b1; JumpE = 1'b0; BranchE = 1'b0; ALUSrcE = 1'b1;
        ResultSrcE = 2'b01; ForwardAE = 2'b00; ForwardBE = 2'b00; Funct3E = 3'b000;
        ALUControlE = ALU_ADD; RdE = 5'd3; RD1E = 32'd5; RD2E = 32'd9; PCE = 32'h100;
        ExtImmE = 32'd7; PCPlus4E = 32'h104; ResultW = 32'd0;

        #1;
        check_m_zero("reset_t0");
        repeat (3) @(posedge clk);
        #1;
        check_m_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        vecs.push_back(mk("add_imm",   ALU_ADD,  1, 0, 0, 32'd5, 32'd0, 32'd7, 0, 0, 0, 0, 32'd12, 32'd0, 0, 32'h107));
        vecs.push_back(mk("add_seed",  ALU_ADD,  1, 0, 0, 32'h10, 32'd0, 32'd0, 0, 0, 0, 0, 32'h10, 32'd0, 0, 32'h100));
        vecs.push_back(mk("fwd_a_mem", ALU_ADD,  0, 2, 0, 32'd0, 32'd1, 32'd0, 0, 0, 0, 0, 32'h11, 32'd1, 0, 32'h100));
        vecs.push_back(mk("fwd_a_wb",  ALU_ADD,  0, 1, 0, 32'd0, 32'd1, 32'd0, 32'h100, 0, 0, 0, 32'h101, 32'd1, 0, 32'h100));
        vecs.push_back(mk("fwd_a_rsv", ALU_ADD,  0, 3, 0, 32'h20, 32'd1, 32'd0, 32'h100, 0, 0, 0, 32'h21, 32'd1, 0, 32'h100));
        vecs.push_back(mk("fwd_b_wb",  ALU_ADD,  0, 0, 1, 32'd2, 32'h55, 32'd0, 32'h300, 0, 0, 0, 32'h302, 32'h300, 0, 32'h100));
        vecs.push_back(mk("sub",       ALU_SUB,  0, 0, 0, 32'd3, 32'd5, 32'd0, 0, 0, 0, 0, 32'hFFFF_FFFE, 32'd5, 0, 32'h100));
        vecs.push_back(mk("sll",       ALU_SLL,  0, 0, 0, 32'd1, 32'd31, 32'd0, 0, 0, 0, 0, 32'h8000_0000, 32'd31, 0, 32'h100));
        vecs.push_back(mk("sll_mask",  ALU_SLL,  0, 0, 0, 32'd1, 32'h21, 32'd0, 0, 0, 0, 0, 32'd2, 32'h21, 0, 32'h100));
        vecs.push_back(mk("slt",       ALU_SLT,  0, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 0, 0, 32'd1, 32'd1, 0, 32'h100));
        vecs.push_back(mk("sltu",      ALU_SLTU, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 0, 0, 32'd0, 32'd1, 0, 32'h100));
        vecs.push_back(mk("sra",       ALU_SRA,  0, 0, 0, 32'h8000_0000, 32'd4, 32'd0, 0, 0, 0, 0, 32'hF800_0000, 32'd4, 0, 32'h100));
        vecs.push_back(mk("srl",       ALU_SRL,  0, 0, 0, 32'h8000_0000, 32'd4, 32'd0, 0, 0, 0, 0, 32'h0800_0000, 32'd4, 0, 32'h100));
        vecs.push_back(mk("xor",       ALU_XOR,  0, 0, 0, 32'hF0F0, 32'hFF00, 32'd0, 0, 0, 0, 0, 32'h0FF0, 32'hFF00, 0, 32'h100));
        vecs.push_back(mk("or",        ALU_OR,   0, 0, 0, 32'hF0F0, 32'hFF00, 32'd0, 0, 0, 0, 0, 32'hFFF0, 32'hFF00, 0, 32'h100));
        vecs.push_back(mk("and",       ALU_AND,  0, 0, 0, 32'hF0F0, 32'hFF00, 32'd0, 0, 0, 0, 0, 32'hF000, 32'hFF00, 0, 32'h100));
        vecs.push_back(mk("lui",       ALU_LUI,  1, 0, 0, 32'd0, 32'd0, 32'h1234_5000, 0, 0, 0, 0, 32'h1234_5000, 32'd0, 0, 32'h1234_5100));
        vecs.push_back(mk("fwd_b_mem", ALU_ADD,  0, 0, 2, 32'd1, 32'd0, 32'd0, 0, 0, 0, 0, 32'h1234_5001, 32'h1234_5000, 0, 32'h100));
        vecs.push_back(mk("beq_taken", ALU_SUB,  0, 0, 0, 32'd3, 32'd3, 32'h20, 0, 0, 1, 3'b000, 32'd0, 32'd3, 1, 32'h120));
        vecs.push_back(mk("bne_not",   ALU_SUB,  0, 0, 0, 32'd3, 32'd3, 32'h20, 0, 0, 1, 3'b001, 32'd0, 32'd3, 0, 32'h120));
        vecs.push_back(mk("blt_taken", ALU_SUB,  0, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'h20, 0, 0, 1, 3'b100, 32'hFFFF_FFFE, 32'd1, 1, 32'h120));
        vecs.push_back(mk("bltu_not",  ALU_SUB,  0, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'h20, 0, 0, 1, 3'b110, 32'hFFFF_FFFE, 32'd1, 0, 32'h120));
        vecs.push_back(mk("bge_taken", ALU_SUB,  0, 0, 0, 32'd1, 32'hFFFF_FFFF, 32'h20, 0, 0, 1, 3'b101, 32'd2, 32'hFFFF_FFFF, 1, 32'h120));
        vecs.push_back(mk("bgeu_not",  ALU_SUB,  0, 0, 0, 32'd1, 32'hFFFF_FFFF, 32'h20, 0, 0, 1, 3'b111, 32'd2, 32'hFFFF_FFFF, 0, 32'h120));
        vecs.push_back(mk("jal",       ALU_ADD,  0, 0, 0, 32'd0, 32'd0, 32'h40, 0, 1, 0, 0, 32'd0, 32'd0, 1, 32'h140));
        vecs.push_back(mk("jalr",      ALU_ADD,  1, 0, 0, 32'h203, 32'd0, 32'h10, 0, 1, 0, 0, 32'h213, 32'd0, 1, 32'h212));
        vecs.push_back(mk("mul",       ALU_MUL,  0, 0, 0, 32'hFFFF_FFFF, 32'd2, 32'd0, 0, 0, 0, 0, MD ? 32'hFFFF_FFFE : 32'd0, 32'd2, 0, 32'h100));
        vecs.push_back(mk("mulh",      ALU_MULH, 0, 0, 0, 32'hFFFF_FFFF, 32'd2, 32'd0, 0, 0, 0, 0, MD ? 32'hFFFF_FFFF : 32'd0, 32'd2, 0, 32'h100));
        vecs.push_back(mk("mulhsu",    ALU_MULHSU, 0, 0, 0, 32'hFFFF_FFFF, 32'd2, 32'd0, 0, 0, 0, 0, MD ? 32'hFFFF_FFFF : 32'd0, 32'd2, 0, 32'h100));
        vecs.push_back(mk("mulhu",     ALU_MULHU, 0, 0, 0, 32'hFFFF_FFFF, 32'd2, 32'd0, 0, 0, 0, 0, MD ? 32'd1 : 32'd0, 32'd2, 0, 32'h100));
        vecs.push_back(mk("mulh_min",  ALU_MULH, 0, 0, 0, 32'h8000_0000, 32'h8000_0000, 32'd0, 0, 0, 0, 0, MD ? 32'h4000_0000 : 32'd0, 32'h8000_0000, 0, 32'h100));
`ifndef MULDIV_EN
        vecs.push_back(mk("div_off",   ALU_DIV,  0, 0, 0, 32'd8, 32'd2, 32'd0, 0, 0, 0, 0, 32'd0, 32'd2, 0, 32'h100));
        vecs.push_back(mk("remu_off",  ALU_REMU, 0, 0, 0, 32'd8, 32'd3, 32'd0, 0, 0, 0, 0, 32'd0, 32'd3, 0, 32'h100));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            logic [31:0] iv;
            v  = vecs[i];
            iv = i;
            ALUControlE = v.op; ALUSrcE = v.src; ForwardAE = v.fa; ForwardBE = v.fb;
            RD1E = v.rd1; RD2E = v.rd2; ExtImmE = v.imm; ResultW = v.resw;
            JumpE = v.jump; BranchE = v.branch; Funct3E = v.f3; PCE = 32'h100;
            RegWriteE = 1'b1; MemWriteE = iv[0]; ResultSrcE = iv[1:0]; RdE = iv[4:0];
            PCPlus4E = 32'h1000 + iv;
            #1;
            check({v.name, "_pcsrc"}, PCSrcE, v.exp_pcsrc);
            check({v.name, "_target"}, PCTargetE, v.exp_tgt);
            check({v.name, "_busy"}, BusyE, 0);
            @(posedge clk); #1;
            check({v.name, "_alu_m"}, ALUResultM, v.exp_alu);
            check({v.name, "_wd_m"}, WriteDataM, v.exp_wd);
            check({v.name, "_regwrite_m"}, RegWriteM, 1);
            check({v.name, "_memwrite_m"}, MemWriteM, iv[0]);
            check({v.name, "_resultsrc_m"}, ResultSrcM, iv[1:0]);
            check({v.name, "_rd_m"}, RdM, iv[4:0]);
            check({v.name, "_pcplus4_m"}, PCPlus4M, 32'h1000 + iv);
        end
        JumpE = 1'b0; BranchE = 1'b0;

`ifdef MULDIV_EN
        run_div("div_m7_2",    ALU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_div("rem_m7_2",    ALU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_div("div_7_m2",    ALU_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        run_div("rem_7_m2",    ALU_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 34);
        run_div("divu_100_7",  ALU_DIVU, 32'd100, 32'd7, 32'd14, 34);
        run_div("remu_100_7",  ALU_REMU, 32'd100, 32'd7, 32'd2, 34);
        run_div("divu_big",    ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
        run_div("divu_5_0",    ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        run_div("remu_5_0",    ALU_REMU, 32'd5, 32'd0, 32'd5, 2);
        run_div("div_m7_0",    ALU_DIV,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 2);
        run_div("rem_m7_0",    ALU_REM,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 2);
        run_div("div_ovf",     ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_div("rem_ovf",     ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);

        // Reset during RUN step 10 abandons the divide.
        ALUControlE = ALU_DIV; RD1E = 32'hFFFF_FFF9; RD2E = 32'd2; ALUSrcE = 1'b0;
        ForwardAE = 2'b00; ForwardBE = 2'b00; RegWriteE = 1'b1; RdE = 5'd4; PCPlus4E = 32'h2000;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        check("mid_div_busy", BusyE, 1);
        check("mid_div_pcplus4_m", PCPlus4M, 32'h2000);
        rst_n = 1'b0;
        #1;
        check_m_zero("mid_div_reset");
        ALUControlE = ALU_ADD;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("after_reset_busy", BusyE, 0);
        run_div("div_reissue", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
